// File: rtl/imem_arb_pkg.sv
// Shared constants for the instruction-memory arbiter.
// Requester IDs double as grant-vector bit indices.
package imem_arb_pkg;

  localparam int REQ_IF = 0;
  localparam int REQ_LS = 1;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin or fixed fetch priority.
// Ports: clk, rst, req[1:0] in; gnt[1:0] out (one-hot or zero).
module rr_arb2
  import imem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Holds the ID of the most recent winner.
  logic last_gnt;

  always_comb begin
    gnt = '0;
    if (!rst) begin
      unique case (req)
        2'b01: gnt[REQ_IF] = 1'b1;
        2'b10: gnt[REQ_LS] = 1'b1;
        2'b11: begin
          if (FIXED_PRIO || last_gnt == 1'(REQ_LS))
            gnt[REQ_IF] = 1'b1;
          else
            gnt[REQ_LS] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
  end

  // Reset to LS so fetch wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_gnt <= 1'(REQ_LS);
    else if (|gnt)
      last_gnt <= gnt[REQ_LS];
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational instruction memory between fetch and loader.
// Ports: if_*/ls_* request ports, mem_addr/mem_dword, conflict_cnt.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dword,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0] req;
  logic [1:0] gnt;

  assign req[REQ_IF] = if_req;
  assign req[REQ_LS] = ls_req;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt)
  );

  assign if_gnt   = gnt[REQ_IF];
  assign ls_gnt   = gnt[REQ_LS];
  assign mem_addr = ls_gnt ? ls_addr : if_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid    <= 1'b0;
      ls_rvalid    <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
      conflict_cnt <= '0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_gnt;
      if (if_gnt)
        if_rdata <= mem_dword;
      if (ls_gnt)
        ls_rdata <= mem_dword;
      if (if_req && ls_req && conflict_cnt != CNT_MAX)
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter (round-robin and fixed-priority).
// Stimulus pushes expected read data; a monitor pops on rvalid.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic [29:0] ls_addr = '0;
  logic [31:0] mem_dword = '0;

  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata;
  logic [29:0] mem_addr;
  logic [15:0] conflict_cnt;

  logic        f_if_gnt, f_if_rvalid, f_ls_gnt, f_ls_rvalid;
  logic [31:0] f_if_rdata, f_ls_rdata;
  logic [29:0] f_mem_addr;
  logic [15:0] f_conflict_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] qif[$];
  logic [31:0] qls[$];
  logic [15:0] exp_cnt = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(30), .DATA_W(32), .FIXED_PRIO(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_dword(mem_dword),
    .conflict_cnt(conflict_cnt)
  );

  imem_arbiter #(.ADDR_W(30), .DATA_W(32), .FIXED_PRIO(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(f_if_gnt),
    .if_rvalid(f_if_rvalid), .if_rdata(f_if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(f_ls_gnt),
    .ls_rvalid(f_ls_rvalid), .ls_rdata(f_ls_rdata),
    .mem_addr(f_mem_addr), .mem_dword(mem_dword),
    .conflict_cnt(f_conflict_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response pushed before an edge must appear right after it.
  always @(posedge clk) begin
    #4;
    if (rst) begin
      last_if = '0;
      last_ls = '0;
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    end else begin
      chk("if_rvalid", 32'(if_rvalid), 32'(qif.size() != 0));
      if (qif.size() != 0) last_if = qif.pop_front();
      chk("if_rdata", if_rdata, last_if);
      chk("ls_rvalid", 32'(ls_rvalid), 32'(qls.size() != 0));
      if (qls.size() != 0) last_ls = qls.pop_front();
      chk("ls_rdata", ls_rdata, last_ls);
    end
  end

  task automatic cyc(input logic ir, input logic [29:0] ia,
                     input logic lr, input logic [29:0] la,
                     input logic [31:0] d,
                     input logic eif, input logic els);
    @(posedge clk);
    #1;
    if_req = ir;
    if_addr = ia;
    ls_req = lr;
    ls_addr = la;
    mem_dword = d;
    #5;
    chk("if_gnt", 32'(if_gnt), 32'(eif));
    chk("ls_gnt", 32'(ls_gnt), 32'(els));
    chk("mem_addr", 32'(mem_addr), 32'(els ? la : ia));
    chk("fp_if_gnt", 32'(f_if_gnt), 32'(ir));
    chk("fp_ls_gnt", 32'(f_ls_gnt), 32'(lr & ~ir));
    chk("fp_mem_addr", 32'(f_mem_addr), 32'((lr & ~ir) ? la : ia));
    if (eif) qif.push_back(d);
    if (els) qls.push_back(d);
    if (ir && lr && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  task automatic idle();
    cyc(1'b0, 30'd0, 1'b0, 30'd0, 32'h0, 1'b0, 1'b0);
  endtask

  // Only meaningful after an idle cycle, so every counted edge has passed.
  task automatic chk_cnt();
    chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    chk("fp_conflict_cnt", 32'(f_conflict_cnt), 32'(exp_cnt));
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_req = 1'b1;
    ls_req = 1'b1;
    qif.delete();
    qls.delete();
    exp_cnt = '0;
    #2;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_fp_if_gnt", 32'(f_if_gnt), 32'd0);
    chk("rst_fp_ls_gnt", 32'(f_ls_gnt), 32'd0);
    chk("rst_fp_rv", 32'({f_if_rvalid, f_ls_rvalid}), 32'd0);
    chk("rst_fp_rdata", f_if_rdata | f_ls_rdata, 32'd0);
    chk("rst_fp_cnt", 32'(f_conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst_pulse();

    // Conflicts: RR alternates IF,LS,IF,LS; fixed prio always IF.
    cyc(1'b1, 30'h40, 1'b1, 30'h80, 32'hA0, 1'b1, 1'b0);
    cyc(1'b1, 30'h40, 1'b1, 30'h80, 32'hA1, 1'b0, 1'b1);
    cyc(1'b1, 30'h41, 1'b1, 30'h81, 32'hA2, 1'b1, 1'b0);
    cyc(1'b1, 30'h42, 1'b1, 30'h81, 32'hA3, 1'b0, 1'b1);
    idle();
    chk_cnt();

    // Single fetch read.
    rst_pulse();
    cyc(1'b1, 30'h10, 1'b0, 30'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    idle();
    idle();

    // Loader burst.
    cyc(1'b0, 30'h0, 1'b1, 30'h1, 32'h111, 1'b0, 1'b1);
    cyc(1'b0, 30'h0, 1'b1, 30'h2, 32'h222, 1'b0, 1'b1);
    cyc(1'b0, 30'h0, 1'b1, 30'h3, 32'h333, 1'b0, 1'b1);
    idle();
    idle();

    // Reset with a response in flight drops it.
    cyc(1'b1, 30'h20, 1'b0, 30'h0, 32'hCAFEF00D, 1'b1, 1'b0);
    rst_pulse();
    idle();
    cyc(1'b1, 30'h30, 1'b1, 30'h31, 32'h5555, 1'b1, 1'b0);
    cyc(1'b1, 30'h30, 1'b1, 30'h31, 32'h6666, 1'b0, 1'b1);

    // Drive the counter to 0xFFFE, then into saturation.
    for (int i = 0; i < 65532; i++)
      cyc(1'b1, 30'(i), 1'b1, 30'(i + 1), 32'(i),
          i[0] == 1'b0, i[0] == 1'b1);
    idle();
    chk_cnt();
    cyc(1'b1, 30'h5, 1'b1, 30'h6, 32'h77, 1'b1, 1'b0);
    cyc(1'b1, 30'h5, 1'b1, 30'h6, 32'h88, 1'b0, 1'b1);
    idle();
    chk_cnt();
    cyc(1'b1, 30'h7, 1'b1, 30'h8, 32'h99, 1'b1, 1'b0);
    idle();
    chk_cnt();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
